aui_generator: RTL and testbench

//   Transmit-side AUI lane distributor for the 1.6T Ethernet datapath.

---
 rtl/aui_generator.sv | 58 +++++
 tb/tb_aui_generator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/aui_generator.sv
// ---------------------------------------------------------------------------
// aui_generator : round-robin AUI lane distributor with periodic AM rounds
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aui_generator #(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    NUMBER_LANES = 16,
  parameter int                    AM_INTERVAL  = 4,
  parameter logic [DATA_WIDTH-1:0] AM_PATTERN   = 64'hC168_21F4_3E97_DE00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] tx_lane [NUMBER_LANES]
);

  localparam int PTR_W = (NUMBER_LANES > 1) ? $clog2(NUMBER_LANES) : 1;
  localparam int RND_W = (AM_INTERVAL > 1) ? $clog2(AM_INTERVAL) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUMBER_LANES - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(AM_INTERVAL - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [RND_W-1:0] RND_ONE  = RND_W'(1);

  logic [PTR_W-1:0]      ptr;
  logic [RND_W-1:0]      rnd;
  logic [7:0]            lane_idx;
  logic [DATA_WIDTH-1:0] am_word;
  logic [DATA_WIDTH-1:0] wr_word;

  // The AM word carries the lane number in its low byte so the receiver can reorder lanes.
  assign lane_idx = 8'(ptr);
  assign am_word  = {AM_PATTERN[DATA_WIDTH-1:8], lane_idx};
  assign wr_word  = (rnd == '0) ? am_word : i_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      rnd <= '0;
      for (int i = 0; i < NUMBER_LANES; i++) begin
        tx_lane[i] <= '0;
      end
    end else begin
      if (ptr == PTR_LAST) begin
        ptr <= '0;
        rnd <= (rnd == RND_LAST) ? '0 : rnd + RND_ONE;
      end else begin
        ptr <= ptr + PTR_ONE;
      end
      tx_lane[ptr] <= wr_word;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aui_generator.sv
// ---------------------------------------------------------------------------
// tb_aui_generator : table-driven and scoreboard checks for aui_generator
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aui_generator;

  localparam int          NL      = 16;
  localparam logic [63:0] AM_BASE = 64'hC168_21F4_3E97_DE00;

  logic        clk;
  logic        rst_n;
  logic [63:0] i_data;
  logic [63:0] tx_lane [NL];

  aui_generator #(
    .DATA_WIDTH   (64),
    .NUMBER_LANES (NL),
    .AM_INTERVAL  (4),
    .AM_PATTERN   (64'hC168_21F4_3E97_DE00)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (i_data),
    .tx_lane (tx_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [63:0] word;
  } exp_t;

  typedef struct {
    int          edges;
    logic [63:0] data;
    int          lane_a;
    logic [63:0] val_a;
    int          lane_b;
    logic [63:0] val_b;
  } vec_t;

  exp_t        sb[$];
  logic [63:0] m_lane [NL];
  int          m_ptr;
  int          m_rnd;
  int          n_checks;
  int          n_fail;
  vec_t        vec [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_rnd = 0;
    for (int i = 0; i < NL; i++) m_lane[i] = '0;
    sb.delete();
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < NL; i++)
      check($sformatf("%s_lane%0d", name, i), tx_lane[i], m_lane[i]);
  endtask

  // Called at a negedge: drive one word, predict the lane write, check after the posedge.
  task automatic step(input logic [63:0] d);
    exp_t e;
    i_data = d;
    e.lane = m_ptr;
    e.word = (m_rnd == 0) ? (AM_BASE | 64'(m_ptr)) : d;
    sb.push_back(e);
    m_lane[m_ptr] = e.word;
    if (m_ptr == NL - 1) begin
      m_ptr = 0;
      m_rnd = (m_rnd + 1) % 4;
    end else begin
      m_ptr++;
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check($sformatf("write_lane%0d", e.lane), tx_lane[e.lane], e.word);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vec[0] = '{16, 64'hFFFF,            3,  64'hC16821F43E97DE03, 15, 64'hC16821F43E97DE0F};
    vec[1] = '{8,  64'hFFFF,            7,  64'h000000000000FFFF, 8,  64'hC16821F43E97DE08};
    vec[2] = '{8,  64'hFFFF,            15, 64'h000000000000FFFF, 0,  64'h000000000000FFFF};
    vec[3] = '{8,  64'hFFFF,            7,  64'h000000000000FFFF, 8,  64'h000000000000FFFF};
    vec[4] = '{8,  64'h5555554,         8,  64'h0000000005555554, 7,  64'h000000000000FFFF};
    vec[5] = '{8,  64'h5555554,         0,  64'h0000000005555554, 15, 64'h0000000005555554};
    vec[6] = '{8,  64'h1234,            8,  64'h0000000000001234, 0,  64'h0000000005555554};
    vec[7] = '{16, 64'hDEADBEEF,        0,  64'hC16821F43E97DE00, 10, 64'hC16821F43E97DE0A};
    vec[8] = '{16, 64'h0123456789ABCDEF, 0, 64'h0123456789ABCDEF, 15, 64'h0123456789ABCDEF};
    vec[9] = '{9,  64'hFEDCBA9876543210, 8, 64'hFEDCBA9876543210, 9,  64'h0123456789ABCDEF};

    model_reset();
    rst_n  = 1'b0;
    i_data = 64'hFFFF;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end

    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < vec[r].edges; k++) step(vec[r].data);
      check($sformatf("table%0d_a_lane%0d", r, vec[r].lane_a), tx_lane[vec[r].lane_a], vec[r].val_a);
      check($sformatf("table%0d_b_lane%0d", r, vec[r].lane_b), tx_lane[vec[r].lane_b], vec[r].val_b);
    end
    check_all("pre_reset");

    // ptr=9, rnd=2 here: assert reset between edges and expect an immediate clear.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_held");

    @(negedge clk);
    rst_n = 1'b1;
    step(64'hFFFF);
    check("restart_lane0_am", tx_lane[0], 64'hC16821F43E97DE00);
    check("restart_lane1_zero", tx_lane[1], 64'h0);
    for (int k = 0; k < 15; k++) step(64'hABCD);
    check_all("restart_round");
    check("restart_lane15_am", tx_lane[15], 64'hC16821F43E97DE0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
